wr_channel_arbiter: RTL and testbench
=====================================

# wr_channel_arbiter

- Round-robin arbiter and sequencer that shares the single DMA write channel (request, data, response) among `NUM_DECOMPRESSOR` decompressor instances.
- Grants the channel for exactly one burst at a time. While granted, it issues the burst request with a per-decompressor running destination address, steers beats via a one-hot grant, and waits for the write response before re-arbitrating.
- Sits between the decompressor array and the DMA write port, in place of static write-channel selection.

## Interface

- `NUM_DECOMPRESSOR`, 2: number of requesters, 1..16.
- `C_M_AXI_ADDR_WIDTH`, 64: address width.
- `BEAT_BYTES`, 64: bytes per data beat, power of two.
- `clk` in 1: single clock. All logic is on the rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `job_id_i` in 16: decompressor index for an address load.
- `job_valid_i` in 1: one-cycle pulse; loads `des_addr` into slot `job_id_i`. Indices ≥ N are ignored.
- `des_addr` in `C_M_AXI_ADDR_WIDTH`: destination base address.
- `dec_burst_req` in N: bit j high means decompressor j has a complete burst buffered. Level signal, held until granted.
- `dec_burst_len` in 8*N: flattened; byte j is the beat count minus 1 for decompressor j's pending burst.
- `wr_req` out 1: burst request to the DMA.
- `wr_address` out `C_M_AXI_ADDR_WIDTH`: burst address.
- `wr_len` out 8: beats minus 1.
- `wr_req_ack` in 1: DMA accepted the request.
- `wr_dec_valid` out N: one-hot data grant; zero outside DATA.
- `wr_valid` in 1: selected beat is valid (OR of granted decompressor's valid).
- `wr_ready` in 1: DMA accepts the beat.
- `wr_axi_last` in 1: last beat of the burst.
- `bready` out 1: response ready.
- `bresp` in 1: write response received.
- `busy` out 1: not in IDLE.
- `err` out 1: sticky protocol error; cleared only by reset.

## Operation

States: IDLE, REQ, DATA, RESP.

**IDLE**
- If `dec_burst_req` ≠ 0, choose the first set bit searching upward from `last_grant+1` (mod N).
- Register the choice as `grant` and latch its `dec_burst_len` byte into `wr_len`. Go to REQ.

**REQ**
- `wr_req`=1, `wr_address`=`addr[grant]`.
- On `wr_req_ack`:
  - `addr[grant]` += (`wr_len`+1)*`BEAT_BYTES`, modulo 2^`C_M_AXI_ADDR_WIDTH`.
  - Go to DATA.

**DATA**
- `wr_dec_valid`=1<<`grant`.
- Count beats on `wr_valid & wr_ready`.
- On the accepted beat with `wr_axi_last`:
  - If beat count ≠ `wr_len`+1, set `err`.
  - Go to RESP.
- A beat count reaching `wr_len`+1 without `wr_axi_last` also sets `err`; stay in DATA until last.

**RESP**
- `bready`=1.
- On `bresp`: `last_grant`←`grant`, go to IDLE.

**Address loads**
- `addr[j]` is loaded by `job_valid_i` in any state.
- If a load and the ack increment hit the same slot in the same cycle, the load wins.

**Reset and fairness**
- Reset at any point returns to IDLE immediately and discards any in-flight burst.
- After reset, `last_grant`=N-1, so index 0 has first priority.
- Requests that drop while not granted are simply skipped.

## Timing

- Reset values:
  - `wr_req`, `bready`, `busy`, `err` = 0.
  - `wr_dec_valid` = 0; `wr_address` = `addr[0]` = 0; `wr_len` = 0.
  - All `addr[]` = 0.
- Request latency: `dec_burst_req` rising in IDLE at cycle t gives `wr_req`=1 at t+1.
- `wr_req` holds with a stable address and length until the ack cycle. It drops the cycle after the ack.
- `wr_dec_valid` is asserted from the cycle after the ack through the last-beat cycle inclusive.
- `bready` is asserted from the cycle after the last beat until the `bresp` cycle inclusive.
- Minimum turnaround from `bresp` to the next `wr_req` is 2 cycles (RESP→IDLE→REQ).
- Exactly one burst is outstanding at any time. `busy`=1 in REQ, DATA and RESP.

## Configuration

- Macro: `WR_ARB_WATCHDOG_EN`.
- When defined:
  - A 10-bit counter clears on every state change and increments in REQ, DATA or RESP.
  - Reaching 1023 sets `err`, forces the FSM to IDLE and clears `wr_dec_valid`.
- When undefined: no counter; the FSM waits indefinitely in each state.

## Test plan

- Reset, then `job_valid_i` with id 0 and `des_addr`=0x1000, and `dec_burst_req`=01 with len 63 → `wr_req`=1 with `wr_address`=0x1000 and `wr_len`=63; after 64 beats and `bresp`, `addr[0]`=0x2000.
- Both requesters held continuously → grants alternate 0,1,0,1, each separated by a full REQ/DATA/RESP sequence.
- `wr_axi_last` on beat 10 with `wr_len`=15 → `err`=1, FSM goes to RESP and continues normally.
- `job_valid_i` for slot 1 in the same cycle as the ack for grant 1 → `addr[1]` equals the new `des_addr`, not incremented.
- `rst_n` pulled low mid-DATA → `wr_dec_valid`=0 and `busy`=0 asynchronously; the next grant goes to index 0.
- With `WR_ARB_WATCHDOG_EN`: withhold `bresp` → `err`=1 after 1023 RESP cycles, FSM returns to IDLE.

Source files
------------

// File: rtl/wr_channel_arbiter.sv
// wr_channel_arbiter: round-robin owner of the shared DMA write channel.
// One burst at a time: arbitrate, issue the request at the winner's running
// destination address, steer data beats by one-hot grant, wait for the response.
// Optional build macro WR_ARB_WATCHDOG_EN adds a stall watchdog that flags err
// and returns the FSM to idle after 1023 cycles without a state change.
module wr_channel_arbiter #(
  parameter int unsigned NUM_DECOMPRESSOR   = 2,
  parameter int unsigned C_M_AXI_ADDR_WIDTH = 64,
  parameter int unsigned BEAT_BYTES         = 64
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [15:0]                     job_id_i,
  input  logic                            job_valid_i,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   des_addr,
  input  logic [NUM_DECOMPRESSOR-1:0]     dec_burst_req,
  input  logic [8*NUM_DECOMPRESSOR-1:0]   dec_burst_len,
  output logic                            wr_req,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   wr_address,
  output logic [7:0]                      wr_len,
  input  logic                            wr_req_ack,
  output logic [NUM_DECOMPRESSOR-1:0]     wr_dec_valid,
  input  logic                            wr_valid,
  input  logic                            wr_ready,
  input  logic                            wr_axi_last,
  output logic                            bready,
  input  logic                            bresp,
  output logic                            busy,
  output logic                            err
);

  localparam int unsigned N         = NUM_DECOMPRESSOR;
  localparam int unsigned AW        = C_M_AXI_ADDR_WIDTH;
  localparam int unsigned GrantW    = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned BeatShift = $clog2(BEAT_BYTES);

  typedef enum logic [1:0] {StIdle, StReq, StData, StResp} state_e;

  state_e              state_q;
  logic [GrantW-1:0]   grant_q, last_grant_q, pick;
  logic                pick_found;
  logic [7:0]          pick_len;
  logic [7:0]          wr_len_q;
  logic [8:0]          beat_cnt_q, beat_cnt_nxt, burst_beats;
  logic [AW-1:0]       burst_bytes;
  logic [AW-1:0]       addr_q [N];
  logic                wr_req_q, bready_q, err_q;
  logic [N-1:0]        wr_dec_valid_q;
  logic                beat_acc, ack_fire, wd_fire;
  logic [2*N-1:0]      req_dbl;
  logic [N-1:0]        req_rot;

  assign beat_acc     = wr_valid & wr_ready;
  assign ack_fire     = (state_q == StReq) & wr_req_ack;
  assign burst_beats  = {1'b0, wr_len_q} + 9'd1;
  assign beat_cnt_nxt = beat_cnt_q + 9'd1;
  assign burst_bytes  = AW'(burst_beats) << BeatShift;
  assign req_dbl      = {dec_burst_req, dec_burst_req};

  // Round-robin pick: rotate requests so the search starts at last_grant+1.
  always_comb begin
    int unsigned sh, off, sum;
    sh         = 32'(last_grant_q) + 32'd1;
    req_rot    = N'(req_dbl >> sh);
    off        = 0;
    pick_found = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!pick_found && req_rot[i]) begin
        off        = i;
        pick_found = 1'b1;
      end
    end
    sum = sh + off;
    if (sum >= N) sum = sum - N;
    if (sum >= N) sum = sum - N;
    pick = GrantW'(sum);
  end

  // Length byte of the candidate and address of the current grant.
  always_comb begin
    pick_len   = dec_burst_len[7:0];
    wr_address = addr_q[0];
    for (int j = 0; j < int'(N); j++) begin
      if (pick == GrantW'(j)) pick_len = dec_burst_len[j*8 +: 8];
      if (grant_q == GrantW'(j)) wr_address = addr_q[j];
    end
  end

`ifdef WR_ARB_WATCHDOG_EN
  logic [9:0] wd_q;
  logic       state_leave;

  assign state_leave = ((state_q == StIdle) & pick_found) | ack_fire |
                       ((state_q == StData) & beat_acc & wr_axi_last) |
                       ((state_q == StResp) & bresp);
  assign wd_fire     = (wd_q == 10'd1023);

  // Stall counter: restarts on every state change, runs while not idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_q <= '0;
    end else if (wd_fire || state_leave || state_q == StIdle) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_q + 10'd1;
    end
  end
`else
  assign wd_fire = 1'b0;
`endif

  // Per-requester running destination addresses; a job load beats the ack bump.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < int'(N); j++) addr_q[j] <= '0;
    end else begin
      for (int j = 0; j < int'(N); j++) begin
        if (job_valid_i && job_id_i == 16'(j)) begin
          addr_q[j] <= des_addr;
        end else if (ack_fire && grant_q == GrantW'(j)) begin
          addr_q[j] <= addr_q[j] + burst_bytes;
        end
      end
    end
  end

  // Channel sequencer with registered request, grant and response-ready outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      grant_q        <= '0;
      last_grant_q   <= GrantW'(N - 1);
      wr_len_q       <= '0;
      beat_cnt_q     <= '0;
      wr_req_q       <= 1'b0;
      bready_q       <= 1'b0;
      wr_dec_valid_q <= '0;
      err_q          <= 1'b0;
    end else if (wd_fire) begin
      state_q        <= StIdle;
      wr_req_q       <= 1'b0;
      bready_q       <= 1'b0;
      wr_dec_valid_q <= '0;
      err_q          <= 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (pick_found) begin
            grant_q  <= pick;
            wr_len_q <= pick_len;
            wr_req_q <= 1'b1;
            state_q  <= StReq;
          end
        end
        StReq: begin
          if (wr_req_ack) begin
            wr_req_q       <= 1'b0;
            wr_dec_valid_q <= N'(1) << grant_q;
            beat_cnt_q     <= '0;
            state_q        <= StData;
          end
        end
        StData: begin
          if (beat_acc) begin
            beat_cnt_q <= beat_cnt_nxt;
            if (wr_axi_last) begin
              if (beat_cnt_nxt != burst_beats) err_q <= 1'b1;
              wr_dec_valid_q <= '0;
              bready_q       <= 1'b1;
              state_q        <= StResp;
            end else if (beat_cnt_nxt == burst_beats) begin
              // Full length reached but no last flag: keep waiting for last.
              err_q <= 1'b1;
            end
          end
        end
        StResp: begin
          if (bresp) begin
            bready_q     <= 1'b0;
            last_grant_q <= grant_q;
            state_q      <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign wr_req       = wr_req_q;
  assign wr_len       = wr_len_q;
  assign wr_dec_valid = wr_dec_valid_q;
  assign bready       = bready_q;
  assign busy         = (state_q != StIdle);
  assign err          = err_q;

endmodule

// File: tb/tb_wr_channel_arbiter.sv
// Directed bench for wr_channel_arbiter (N=2, 64-bit address, 64-byte beats).
module tb_wr_channel_arbiter;

  localparam int N  = 2;
  localparam int AW = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [15:0]   job_id_i = '0;
  logic          job_valid_i = 1'b0;
  logic [AW-1:0] des_addr = '0;
  logic [N-1:0]  dec_burst_req = '0;
  logic [8*N-1:0] dec_burst_len = '0;
  logic          wr_req;
  logic [AW-1:0] wr_address;
  logic [7:0]    wr_len;
  logic          wr_req_ack = 1'b0;
  logic [N-1:0]  wr_dec_valid;
  logic          wr_valid = 1'b0;
  logic          wr_ready = 1'b0;
  logic          wr_axi_last = 1'b0;
  logic          bready;
  logic          bresp = 1'b0;
  logic          busy;
  logic          err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  wr_channel_arbiter #(
    .NUM_DECOMPRESSOR  (N),
    .C_M_AXI_ADDR_WIDTH(AW),
    .BEAT_BYTES        (64)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .job_id_i     (job_id_i),
    .job_valid_i  (job_valid_i),
    .des_addr     (des_addr),
    .dec_burst_req(dec_burst_req),
    .dec_burst_len(dec_burst_len),
    .wr_req       (wr_req),
    .wr_address   (wr_address),
    .wr_len       (wr_len),
    .wr_req_ack   (wr_req_ack),
    .wr_dec_valid (wr_dec_valid),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_axi_last  (wr_axi_last),
    .bready       (bready),
    .bresp        (bresp),
    .busy         (busy),
    .err          (err)
  );

  initial begin
    #500000;
    $display("FAIL global_timeout: sim still running, required finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    job_valid_i = 1'b0; dec_burst_req = '0; wr_req_ack = 1'b0;
    wr_valid = 1'b0; wr_ready = 1'b0; wr_axi_last = 1'b0; bresp = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic load_addr(input int id, input logic [AW-1:0] a);
    job_id_i = 16'(id); des_addr = a; job_valid_i = 1'b1;
    tick();
    job_valid_i = 1'b0;
  endtask

  task automatic do_ack();
    wr_req_ack = 1'b1;
    tick();
    wr_req_ack = 1'b0;
  endtask

  task automatic do_resp();
    bresp = 1'b1;
    tick();
    bresp = 1'b0;
  endtask

  // Drives n accepted beats (one ready stall before beat 2); last flag on beat last_at.
  task automatic send_beats(input int n, input int last_at, input logic [N-1:0] exp_dv,
                            output int dv_bad);
    dv_bad = 0;
    for (int k = 1; k <= n; k++) begin
      if (k == 2) begin
        wr_valid = 1'b1; wr_ready = 1'b0; wr_axi_last = 1'b0;
        tick();
      end
      wr_valid = 1'b1; wr_ready = 1'b1; wr_axi_last = (k == last_at);
      if (wr_dec_valid !== exp_dv) dv_bad++;
      tick();
    end
    wr_valid = 1'b0; wr_ready = 1'b0; wr_axi_last = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_tests++;
    if ({wr_req, bready, busy, err} !== 4'b0000) begin
      $display("FAIL reset_ctrl: got %b, expected 0000", {wr_req, bready, busy, err});
      n_fail++;
    end
    n_tests++;
    if (wr_dec_valid !== 2'b00 || wr_len !== 8'd0) begin
      $display("FAIL reset_dv_len: got dv=%b len=%0d, expected 00/0", wr_dec_valid, wr_len);
      n_fail++;
    end
    n_tests++;
    if (wr_address !== 64'h0) begin
      $display("FAIL reset_addr: got %h, expected 0", wr_address);
      n_fail++;
    end
  endtask

  task automatic test_single_burst();
    int bad;
    load_addr(0, 64'h1000);
    dec_burst_len = {8'd0, 8'd63};
    dec_burst_req = 2'b01;
    tick();
    n_tests++;
    if ({wr_req, wr_address, wr_len} !== {1'b1, 64'h1000, 8'd63}) begin
      $display("FAIL single_req: got req=%b addr=%h len=%0d, expected 1/1000/63",
               wr_req, wr_address, wr_len);
      n_fail++;
    end
    dec_burst_req = 2'b00;
    tick();
    n_tests++;
    if ({wr_req, wr_address, busy} !== {1'b1, 64'h1000, 1'b1}) begin
      $display("FAIL single_req_hold: got req=%b addr=%h busy=%b, expected 1/1000/1",
               wr_req, wr_address, busy);
      n_fail++;
    end
    do_ack();
    n_tests++;
    if ({wr_req, wr_dec_valid} !== 3'b001) begin
      $display("FAIL single_ack: got req=%b dv=%b, expected 0/01", wr_req, wr_dec_valid);
      n_fail++;
    end
    send_beats(64, 64, 2'b01, bad);
    n_tests++;
    if (bad !== 0 || {wr_dec_valid, bready, err} !== 4'b0010) begin
      $display("FAIL single_data: got bad=%0d dv=%b bready=%b err=%b, expected 0/00/1/0",
               bad, wr_dec_valid, bready, err);
      n_fail++;
    end
    do_resp();
    n_tests++;
    if ({busy, bready} !== 2'b00) begin
      $display("FAIL single_resp: got busy=%b bready=%b, expected 0/0", busy, bready);
      n_fail++;
    end
    dec_burst_len = {8'd0, 8'd0};
    dec_burst_req = 2'b01;
    tick();
    dec_burst_req = 2'b00;
    n_tests++;
    if (wr_address !== 64'h2000) begin
      $display("FAIL single_next_addr: got %h, expected 2000", wr_address);
      n_fail++;
    end
    do_ack();
    send_beats(1, 1, 2'b01, bad);
    do_resp();
  endtask

  task automatic test_round_robin();
    int bad, total_bad;
    logic [AW-1:0] a0, a1, ea;
    logic [7:0] el;
    logic [N-1:0] edv;
    apply_reset();
    load_addr(1, 64'h8000);
    a0 = 64'h0; a1 = 64'h8000; total_bad = 0;
    dec_burst_len = {8'd3, 8'd1};
    dec_burst_req = 2'b11;
    for (int it = 0; it < 4; it++) begin
      tick();
      ea  = (it % 2 == 1) ? a1 : a0;
      el  = (it % 2 == 1) ? 8'd3 : 8'd1;
      edv = (it % 2 == 1) ? 2'b10 : 2'b01;
      n_tests++;
      if ({wr_req, wr_address, wr_len} !== {1'b1, ea, el}) begin
        $display("FAIL rr_req%0d: got req=%b addr=%h len=%0d, expected 1/%h/%0d",
                 it, wr_req, wr_address, wr_len, ea, el);
        n_fail++;
      end
      do_ack();
      n_tests++;
      if (wr_dec_valid !== edv) begin
        $display("FAIL rr_grant%0d: got %b, expected %b", it, wr_dec_valid, edv);
        n_fail++;
      end
      send_beats(int'(el) + 1, int'(el) + 1, edv, bad);
      total_bad += bad;
      do_resp();
      if (it % 2 == 1) a1 = a1 + (AW'(el) + 1) * 64;
      else             a0 = a0 + (AW'(el) + 1) * 64;
    end
    dec_burst_req = 2'b00;
    n_tests++;
    if (total_bad !== 0 || err !== 1'b0) begin
      $display("FAIL rr_data: got bad=%0d err=%b, expected 0/0", total_bad, err);
      n_fail++;
    end
  endtask

  task automatic test_short_burst_err();
    int bad;
    dec_burst_len = {8'd0, 8'd15};
    dec_burst_req = 2'b01;
    tick();
    dec_burst_req = 2'b00;
    do_ack();
    send_beats(10, 10, 2'b01, bad);
    n_tests++;
    if ({err, bready, wr_dec_valid} !== 4'b1100) begin
      $display("FAIL short_err: got err=%b bready=%b dv=%b, expected 1/1/00",
               err, bready, wr_dec_valid);
      n_fail++;
    end
    do_resp();
    dec_burst_len = {8'd0, 8'd0};
    dec_burst_req = 2'b01;
    tick();
    dec_burst_req = 2'b00;
    n_tests++;
    if (wr_req !== 1'b1) begin
      $display("FAIL short_continue: got req=%b, expected 1", wr_req);
      n_fail++;
    end
    do_ack();
    send_beats(1, 1, 2'b01, bad);
    do_resp();
    n_tests++;
    if ({err, busy} !== 2'b10) begin
      $display("FAIL short_sticky: got err=%b busy=%b, expected 1/0", err, busy);
      n_fail++;
    end
  endtask

  task automatic test_overrun();
    int bad;
    apply_reset();
    dec_burst_len = {8'd0, 8'd1};
    dec_burst_req = 2'b01;
    tick();
    dec_burst_req = 2'b00;
    do_ack();
    send_beats(2, 0, 2'b01, bad);
    n_tests++;
    if ({err, wr_dec_valid, bready} !== 4'b1010) begin
      $display("FAIL overrun: got err=%b dv=%b bready=%b, expected 1/01/0",
               err, wr_dec_valid, bready);
      n_fail++;
    end
    send_beats(1, 1, 2'b01, bad);
    n_tests++;
    if ({bready, wr_dec_valid} !== 3'b100) begin
      $display("FAIL overrun_last: got bready=%b dv=%b, expected 1/00", bready, wr_dec_valid);
      n_fail++;
    end
    do_resp();
  endtask

  task automatic test_load_vs_ack();
    int bad;
    apply_reset();
    load_addr(2, 64'hDEAD);
    load_addr(1, 64'h4000);
    dec_burst_len = {8'd7, 8'd0};
    dec_burst_req = 2'b10;
    tick();
    dec_burst_req = 2'b00;
    n_tests++;
    if ({wr_address, wr_len} !== {64'h4000, 8'd7}) begin
      $display("FAIL lva_req: got addr=%h len=%0d, expected 4000/7", wr_address, wr_len);
      n_fail++;
    end
    wr_req_ack = 1'b1; job_valid_i = 1'b1; job_id_i = 16'd1; des_addr = 64'h9000;
    tick();
    wr_req_ack = 1'b0; job_valid_i = 1'b0;
    send_beats(8, 8, 2'b10, bad);
    do_resp();
    dec_burst_req = 2'b10;
    tick();
    dec_burst_req = 2'b00;
    n_tests++;
    if (wr_address !== 64'h9000) begin
      $display("FAIL lva_load_wins: got %h, expected 9000", wr_address);
      n_fail++;
    end
    do_ack();
    send_beats(8, 8, 2'b10, bad);
    do_resp();
    dec_burst_req = 2'b01;
    tick();
    dec_burst_req = 2'b00;
    n_tests++;
    if ({wr_req, wr_address} !== {1'b1, 64'h0}) begin
      $display("FAIL lva_bad_id: got req=%b addr=%h, expected 1/0", wr_req, wr_address);
      n_fail++;
    end
    do_ack();
    send_beats(1, 1, 2'b01, bad);
    do_resp();
  endtask

  task automatic test_async_reset();
    int bad;
    dec_burst_len = {8'd7, 8'd2};
    dec_burst_req = 2'b10;
    tick();
    dec_burst_req = 2'b00;
    do_ack();
    send_beats(2, 0, 2'b10, bad);
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({wr_dec_valid, busy, wr_req, bready} !== 5'b00000) begin
      $display("FAIL async_rst: got dv=%b busy=%b req=%b bready=%b, expected all 0",
               wr_dec_valid, busy, wr_req, bready);
      n_fail++;
    end
    #2 rst_n = 1'b1;
    tick();
    dec_burst_req = 2'b11;
    tick();
    dec_burst_req = 2'b00;
    n_tests++;
    if ({wr_req, wr_len} !== {1'b1, 8'd2}) begin
      $display("FAIL async_next_req: got req=%b len=%0d, expected 1/2", wr_req, wr_len);
      n_fail++;
    end
    do_ack();
    n_tests++;
    if (wr_dec_valid !== 2'b01) begin
      $display("FAIL async_next_grant: got %b, expected 01", wr_dec_valid);
      n_fail++;
    end
    send_beats(3, 3, 2'b01, bad);
    do_resp();
  endtask

`ifdef WR_ARB_WATCHDOG_EN
  task automatic test_watchdog();
    int bad, waited;
    apply_reset();
    dec_burst_len = {8'd0, 8'd0};
    dec_burst_req = 2'b01;
    tick();
    dec_burst_req = 2'b00;
    do_ack();
    send_beats(1, 1, 2'b01, bad);
    waited = 0;
    while (busy === 1'b1 && waited < 1100) begin
      tick();
      waited++;
    end
    n_tests++;
    if (busy !== 1'b0 || err !== 1'b1 || waited < 1020 || waited > 1030) begin
      $display("FAIL watchdog: got busy=%b err=%b after %0d cycles, expected 0/1 near 1024",
               busy, err, waited);
      n_fail++;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_burst();
    test_round_robin();
    test_short_burst_err();
    test_overrun();
    test_load_vs_ack();
    test_async_reset();
`ifdef WR_ARB_WATCHDOG_EN
    test_watchdog();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
